// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    S_LOAD,
    S_WAIT,
    S_START,
    S_LOOP,
    S_FINAL
  } div_state_t;

  // Width of the iteration counter (at least one bit).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/divider_unit_if.sv
// Button/switch inputs and display outputs of the divider.
interface divider_unit_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);
  logic             load_clear;
  logic             Run;
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output load_clear, Run, SW,
    input  Divisor, Quotient, Remainder, Busy, Done, DivZero
  );

  modport slave (
    input  load_clear, Run, SW,
    output Divisor, Quotient, Remainder, Busy, Done, DivZero
  );
endinterface

// File: rtl/div_datapath.sv
// Divisor/Q/R registers, {R,Q} shifter and trial subtractor of the restoring divider.
module div_datapath #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             ld_div,
  input  logic             start,
  input  logic             shift,
  input  logic             sub_try,
  input  logic             div0,
  output logic             borrow,
  output logic             div_is_zero,
  output logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0]   r;
  logic [WIDTH+1:0] diff;

  // R is one bit wider than the divisor so the shifted partial remainder never overflows.
  assign diff        = {1'b0, r} - {2'b00, divisor};
  assign borrow      = diff[WIDTH+1];
  assign div_is_zero = (divisor == '0);
  assign remainder   = r[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      divisor  <= '0;
      quotient <= '0;
      r        <= '0;
    end else if (ld_div) begin
      divisor  <= sw;
      quotient <= '0;
      r        <= '0;
    end else if (start) begin
      quotient <= div0 ? '1 : sw;
      r        <= div0 ? {1'b0, sw} : '0;
    end else if (shift) begin
      r        <= {r[WIDTH-1:0], quotient[WIDTH-1]};
      quotient <= {quotient[WIDTH-2:0], 1'b0};
    end else if (sub_try && !borrow) begin
      r           <= diff[WIDTH:0];
      quotient[0] <= 1'b1;
    end
  end

endmodule

// File: rtl/divider_unit.sv
// Control FSM, iteration counter and shift/subtract phase of the restoring divider.
module divider_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           Clk,
  input  logic           Reset_n,
  divider_unit_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             div_zero;
  logic             ld_div, start, shift, sub_try;
  logic             borrow, div_is_zero;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_WAIT;
      cnt      <= '0;
      phase    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_LOAD:  div_zero <= 1'b0;
        S_START: begin
          cnt      <= '0;
          phase    <= 1'b0;
          div_zero <= div_is_zero;
        end
        S_LOOP: begin
          phase <= ~phase;
          if (phase) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    ld_div  = 1'b0;
    start   = 1'b0;
    shift   = 1'b0;
    sub_try = 1'b0;
    case (state)
      S_LOAD: begin
        ld_div = 1'b1;
        if (!bus.load_clear) state_n = S_WAIT;
      end
      S_WAIT:  if (bus.Run) state_n = S_START;
      S_START: begin
        start   = 1'b1;
        state_n = div_is_zero ? S_FINAL : S_LOOP;
      end
      S_LOOP: begin
        if (!phase) begin
          shift = 1'b1;
        end else begin
          sub_try = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_n = S_FINAL;
        end
      end
      S_FINAL: if (!bus.Run) state_n = S_WAIT;
      default: state_n = S_WAIT;
    endcase
    // Loading the divisor overrides whatever the FSM was doing.
    if (bus.load_clear) state_n = S_LOAD;
  end

  assign bus.Busy    = (state == S_START) || (state == S_LOOP);
  assign bus.Done    = (state == S_FINAL);
  assign bus.DivZero = div_zero;

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .sw          (bus.SW),
    .ld_div      (ld_div),
    .start       (start),
    .shift       (shift),
    .sub_try     (sub_try),
    .div0        (div_is_zero),
    .borrow      (borrow),
    .div_is_zero (div_is_zero),
    .divisor     (bus.Divisor),
    .quotient    (bus.Quotient),
    .remainder   (bus.Remainder)
  );

endmodule

// File: tb/tb_divider_unit.sv
// Directed-vector bench for divider_unit with hand-computed quotients and remainders.
module tb_divider_unit;
  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  divider_unit_if #(.WIDTH(W)) bus ();

  divider_unit #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_div(input logic [W-1:0] d);
    @(negedge Clk);
    bus.load_clear = 1'b1;
    bus.SW         = d;
    @(negedge Clk);
    @(negedge Clk);
    bus.load_clear = 1'b0;
    @(negedge Clk);
  endtask

  // Start one division; Done must first appear exp_lat edges after the Run-sample edge.
  task automatic divide(input string tag, input logic [W-1:0] dividend,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input logic exp_dz, input int exp_lat, input int hold);
    int n = 0;
    int busy_cnt = 0;
    bit seen = 0;
    @(negedge Clk);
    bus.SW  = dividend;
    bus.Run = 1'b1;
    @(posedge Clk);
    #1;
    if (bus.Busy) busy_cnt++;
    while (!seen && n < 40) begin
      @(posedge Clk);
      n++;
      #1;
      if (bus.Done) seen = 1;
      else if (bus.Busy) busy_cnt++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, exp_lat);
    check({tag, " quotient"}, bus.Quotient, exp_q);
    check({tag, " remainder"}, bus.Remainder, exp_r);
    check({tag, " divzero"}, bus.DivZero, exp_dz);
    if (hold > 0) begin
      repeat (hold) @(posedge Clk);
      #1;
      check({tag, " held done"}, bus.Done, 1);
      check({tag, " held busy"}, bus.Busy, 0);
      check({tag, " held quotient"}, bus.Quotient, exp_q);
    end
    @(negedge Clk);
    bus.Run = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    bus.load_clear = 1'b0;
    bus.Run        = 1'b0;
    bus.SW         = '0;
    #12;
    check("reset divisor", bus.Divisor, 0);
    check("reset quotient", bus.Quotient, 0);
    check("reset busy", bus.Busy, 0);
    check("reset done", bus.Done, 0);
    Reset_n = 1'b1;

    load_div(8'd7);
    check("load divisor", bus.Divisor, 7);
    divide("100/7", 8'd100, 8'd14, 8'd2, 1'b0, 2 * W + 1, 0);

    load_div(8'd1);
    divide("255/1", 8'd255, 8'd255, 8'd0, 1'b0, 2 * W + 1, 0);
    load_div(8'd255);
    divide("255/255", 8'd255, 8'd1, 8'd0, 1'b0, 2 * W + 1, 0);
    load_div(8'd9);
    divide("5/9", 8'd5, 8'd0, 8'd5, 1'b0, 2 * W + 1, 0);
    load_div(8'd200);
    divide("199/200", 8'd199, 8'd0, 8'd199, 1'b0, 2 * W + 1, 0);

    load_div(8'd0);
    divide("42/0", 8'd42, 8'hFF, 8'd42, 1'b1, 1, 0);
    load_div(8'd3);
    check("load clears divzero", bus.DivZero, 0);

    divide("hold 200/3", 8'd200, 8'd66, 8'd2, 1'b0, 2 * W + 1, 40);
    divide("repeat 200/3", 8'd200, 8'd66, 8'd2, 1'b0, 2 * W + 1, 0);

    // Abort with load_clear part-way through the loop; SW also changes mid-run.
    load_div(8'd7);
    @(negedge Clk);
    bus.SW  = 8'd100;
    bus.Run = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.Run = 1'b0;
    bus.SW  = 8'd77;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check("mid-loop busy", bus.Busy, 1);
    bus.load_clear = 1'b1;
    bus.SW         = 8'd33;
    @(posedge Clk);
    #1;
    check("abort busy", bus.Busy, 0);
    check("abort done", bus.Done, 0);
    @(posedge Clk);
    #1;
    check("abort quotient", bus.Quotient, 0);
    check("abort remainder", bus.Remainder, 0);
    check("abort divisor", bus.Divisor, 33);
    @(negedge Clk);
    bus.load_clear = 1'b0;
    @(negedge Clk);

    // Run and load_clear together: load wins.
    bus.Run        = 1'b1;
    bus.load_clear = 1'b1;
    bus.SW         = 8'd5;
    @(posedge Clk);
    #1;
    check("load beats run busy", bus.Busy, 0);
    @(negedge Clk);
    bus.Run        = 1'b0;
    bus.load_clear = 1'b0;
    @(negedge Clk);
    check("load beats run divisor", bus.Divisor, 5);

    // Asynchronous reset in the middle of a run.
    load_div(8'd7);
    @(negedge Clk);
    bus.SW  = 8'd100;
    bus.Run = 1'b1;
    repeat (5) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async rst divisor", bus.Divisor, 0);
    check("async rst quotient", bus.Quotient, 0);
    check("async rst remainder", bus.Remainder, 0);
    check("async rst busy", bus.Busy, 0);
    bus.Run = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;

    load_div(8'd9);
    divide("200/9 after reset", 8'd200, 8'd22, 8'd2, 1'b0, 2 * W + 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
